// File: rtl/avalon_burst_mem_tester_pkg.sv
// avalon_burst_mem_tester_pkg: shared state encodings, pattern modes and LFSR constants
package avalon_burst_mem_tester_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_INIT,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;
   localparam logic [1:0] MODE_ADDR = 2'd0;
   localparam logic [1:0] MODE_LFSR = 2'd1;
   localparam logic [1:0] MODE_WALK = 2'd2;
   localparam logic [1:0] MODE_CHECK = 2'd3;
   localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
   localparam logic [31:0] CHECK_EVEN = 32'h5555_5555;
   localparam logic [31:0] CHECK_ODD = 32'hAAAA_AAAA;
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'd0);
   endfunction
endpackage

// File: rtl/avalon_burst_mem_tester_pattern_gen.sv
// mem_test_pattern_gen: per-word 32-bit test pattern replicated across the data bus
module mem_test_pattern_gen
   import avalon_burst_mem_tester_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter logic [31:0] SEED = 32'hACE1_2345
) (
   input logic clk,
   input logic rst,
   input logic [1:0] mode,
   input logic restart,
   input logic advance,
   output logic [DATA_W-1:0] word
);
   logic [31:0] idx_q, idx_d, lfsr_q, lfsr_d, pat;
   always_comb begin
      idx_d = restart ? 32'd0 : advance ? idx_q + 32'd1 : idx_q;
      lfsr_d = restart ? SEED : advance ? lfsr_next(lfsr_q) : lfsr_q;
      pat = mode == MODE_ADDR ? idx_q :
            mode == MODE_LFSR ? lfsr_q :
            mode == MODE_WALK ? 32'd1 << idx_q[4:0] :
            idx_q[0] ? CHECK_ODD : CHECK_EVEN;
   end
   assign word = {(DATA_W/32){pat}};
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         lfsr_q <= SEED;
      end else begin
         idx_q <= idx_d;
         lfsr_q <= lfsr_d;
      end
   end
endmodule

// File: rtl/avalon_burst_mem_tester.sv
// avalon_burst_mem_tester: Avalon burst write-then-read-back memory tester with pattern compare
module avalon_burst_mem_tester
   import avalon_burst_mem_tester_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 512,
   parameter int BURST_LEN = 4,
   parameter int SIZE_W = 3,
   parameter int NUM_WORDS = 1024,
   parameter logic [31:0] SEED = 32'hACE1_2345
) (
   input logic iCLK,
   input logic iRST,
   input logic iSTART,
   input logic [1:0] iMODE,
   input logic local_init_done,
   input logic avl_waitrequest_n,
   output logic [ADDR_W-1:0] avl_address,
   output logic avl_burstbegin,
   output logic [SIZE_W-1:0] avl_size,
   output logic avl_write,
   output logic [DATA_W-1:0] avl_writedata,
   output logic avl_read,
   input logic avl_readdatavalid,
   input logic [DATA_W-1:0] avl_readdata,
   output logic drv_status_pass,
   output logic drv_status_fail,
   output logic drv_status_test_complete,
   output logic [15:0] err_count,
   output logic [ADDR_W-1:0] first_err_addr
);
   localparam logic [ADDR_W-1:0] LAST_BURST_ADDR = ADDR_W'(NUM_WORDS - BURST_LEN);
   localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
   localparam logic [SIZE_W-1:0] LAST_BEAT = SIZE_W'(BURST_LEN - 1);
   localparam logic [ADDR_W:0] WORDS = (ADDR_W+1)'(NUM_WORDS);

   state_t state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d, first_q, first_d, cmp_addr_q, cmp_addr_d;
   logic [SIZE_W-1:0] beat_q, beat_d;
   logic [ADDR_W:0] rcv_q, rcv_d;
   logic write_q, write_d, read_q, read_d, bb_q, bb_d;
   logic pass_q, pass_d, fail_q, fail_d, done_q, done_d;
   logic cmp_v_q, cmp_v_d, cmp_bad_q, cmp_bad_d;
   logic [15:0] err_q, err_d;
   logic wr_restart, wr_adv, exp_restart, exp_adv, accept;
   logic [DATA_W-1:0] wr_word, exp_word;

   mem_test_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
      .clk(iCLK), .rst(iRST), .mode(mode_q),
      .restart(wr_restart), .advance(wr_adv), .word(wr_word)
   );

   mem_test_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_gen (
      .clk(iCLK), .rst(iRST), .mode(mode_q),
      .restart(exp_restart), .advance(exp_adv), .word(exp_word)
   );

   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      addr_d = addr_q;
      beat_d = beat_q;
      write_d = write_q;
      read_d = read_q;
      bb_d = 1'b0;
      pass_d = pass_q;
      fail_d = fail_q;
      done_d = done_q;
      err_d = err_q;
      first_d = first_q;
      rcv_d = rcv_q;
      cmp_v_d = 1'b0;
      cmp_bad_d = cmp_bad_q;
      cmp_addr_d = cmp_addr_q;
      wr_restart = 1'b0;
      wr_adv = 1'b0;
      exp_restart = 1'b0;
      exp_adv = 1'b0;
      accept = avl_waitrequest_n && (write_q || read_q);
      // compare result retires one cycle after its beat
      if (cmp_v_q && cmp_bad_q) begin
         err_d = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
         first_d = err_q == 16'd0 ? cmp_addr_q : first_q;
      end
      if (avl_readdatavalid && (state_q == ST_READ || state_q == ST_DRAIN) && rcv_q != WORDS) begin
         cmp_v_d = 1'b1;
         cmp_bad_d = avl_readdata != exp_word;
         cmp_addr_d = rcv_q[ADDR_W-1:0];
         rcv_d = rcv_q + 1'b1;
         exp_adv = 1'b1;
      end
      case (state_q)
         ST_IDLE, ST_DONE: if (iSTART) begin
            state_d = ST_WAIT_INIT;
            mode_d = iMODE;
            pass_d = 1'b0;
            fail_d = 1'b0;
            done_d = 1'b0;
            err_d = '0;
            first_d = '0;
            rcv_d = '0;
            wr_restart = 1'b1;
            exp_restart = 1'b1;
         end
         ST_WAIT_INIT: if (local_init_done) begin
            state_d = ST_WRITE;
            write_d = 1'b1;
            bb_d = 1'b1;
            addr_d = '0;
            beat_d = '0;
         end
         ST_WRITE: if (accept) begin
            wr_adv = 1'b1;
            beat_d = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
               beat_d = '0;
               bb_d = 1'b1;
               if (addr_q == LAST_BURST_ADDR) begin
                  state_d = ST_READ;
                  write_d = 1'b0;
                  read_d = 1'b1;
                  addr_d = '0;
                  wr_restart = 1'b1;
               end else begin
                  addr_d = addr_q + BURST_STEP;
               end
            end
         end
         ST_READ: if (accept) begin
            if (addr_q == LAST_BURST_ADDR) begin
               state_d = ST_DRAIN;
               read_d = 1'b0;
            end else begin
               addr_d = addr_q + BURST_STEP;
               bb_d = 1'b1;
            end
         end
         ST_DRAIN: if (rcv_q == WORDS && !cmp_v_q) begin
            state_d = ST_DONE;
            done_d = 1'b1;
            pass_d = err_q == 16'd0;
            fail_d = err_q != 16'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         mode_q <= '0;
         addr_q <= '0;
         beat_q <= '0;
         write_q <= 1'b0;
         read_q <= 1'b0;
         bb_q <= 1'b0;
         pass_q <= 1'b0;
         fail_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= '0;
         first_q <= '0;
         rcv_q <= '0;
         cmp_v_q <= 1'b0;
         cmp_bad_q <= 1'b0;
         cmp_addr_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         addr_q <= addr_d;
         beat_q <= beat_d;
         write_q <= write_d;
         read_q <= read_d;
         bb_q <= bb_d;
         pass_q <= pass_d;
         fail_q <= fail_d;
         done_q <= done_d;
         err_q <= err_d;
         first_q <= first_d;
         rcv_q <= rcv_d;
         cmp_v_q <= cmp_v_d;
         cmp_bad_q <= cmp_bad_d;
         cmp_addr_q <= cmp_addr_d;
      end
   end

   assign avl_address = addr_q;
   assign avl_burstbegin = bb_q;
   assign avl_size = SIZE_W'(BURST_LEN);
   assign avl_write = write_q;
   assign avl_writedata = write_q ? wr_word : '0;
   assign avl_read = read_q;
   assign drv_status_pass = pass_q;
   assign drv_status_fail = fail_q;
   assign drv_status_test_complete = done_q;
   assign err_count = err_q;
   assign first_err_addr = first_q;
endmodule

// File: tb/tb_avalon_burst_mem_tester.sv
// tb_avalon_burst_mem_tester: randomized Avalon memory model and scoreboard for avalon_burst_mem_tester
module tb_avalon_burst_mem_tester;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 128;
   localparam int BL = 4;
   localparam int SIZE_W = 3;
   localparam int NW = 16;
   localparam logic [31:0] SEED = 32'hACE1_2345;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, init_done = 1'b0, wrn = 1'b1, rvalid = 1'b0;
   logic [1:0] mode_in = 2'd0;
   logic [DATA_W-1:0] rdata = '0, wdata;
   logic [ADDR_W-1:0] addr, first_err;
   logic bb, wr, rd, pass, fail, complete;
   logic [SIZE_W-1:0] size;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   avalon_burst_mem_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .SIZE_W(SIZE_W), .NUM_WORDS(NW), .SEED(SEED)
   ) dut (
      .iCLK(clk), .iRST(rst), .iSTART(start), .iMODE(mode_in), .local_init_done(init_done),
      .avl_waitrequest_n(wrn), .avl_address(addr), .avl_burstbegin(bb), .avl_size(size),
      .avl_write(wr), .avl_writedata(wdata), .avl_read(rd), .avl_readdatavalid(rvalid),
      .avl_readdata(rdata), .drv_status_pass(pass), .drv_status_fail(fail),
      .drv_status_test_complete(complete), .err_count(err_cnt), .first_err_addr(first_err)
   );

   int n_checks = 0, n_fail = 0;
   logic [1:0] tb_mode = 2'd0;
   bit stall_en = 1'b0, junk_en = 1'b0, model_reset = 1'b0;
   logic [DATA_W-1:0] mem [NW];
   logic [DATA_W-1:0] corrupt [NW];
   int pend[$];
   int wcnt = 0, rcmd = 0, bb_cnt = 0;
   logic p_req = 1'b0, p_wrn = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
   logic [ADDR_W-1:0] p_addr = '0;
   logic [DATA_W-1:0] p_data = '0;
   logic [SIZE_W-1:0] p_size = '0;

   task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // P(w) straight from the pattern definitions: word index, LFSR stepped w times, walking one, parity checkerboard
   function automatic logic [31:0] pat(input logic [1:0] m, input int w);
      logic [31:0] s;
      logic [31:0] taps;
      s = SEED;
      taps = (32'd1 << 22) | (32'd1 << 2) | (32'd1 << 1) | 32'd1;
      case (m)
         2'd0: return 32'(w);
         2'd1: begin
            for (int i = 0; i < w; i++) s = s[31] ? ((s << 1) ^ taps) : (s << 1);
            return s;
         end
         2'd2: return 32'd1 << (w % 32);
         default: return (w % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
      endcase
   endfunction

   // memory model: accepts what the DUT presented on the previous edge, returns read data in order
   initial begin
      int a;
      forever begin
         @(posedge clk);
         #1;
         if (model_reset) begin
            pend.delete();
            wcnt = 0;
            rcmd = 0;
            bb_cnt = 0;
            p_req = 1'b0;
         end else if (!rst) begin
            if (p_req && p_wrn) begin
               if (p_wr) begin
                  chk("wr_addr", p_addr, (wcnt / BL) * BL);
                  chk("wr_data", p_data, {(DATA_W/32){pat(tb_mode, wcnt)}});
                  a = int'(p_addr) + wcnt % BL;
                  if (a < NW) mem[a] = p_data;
                  wcnt++;
               end else begin
                  chk("rd_addr", p_addr, rcmd * BL);
                  for (int i = 0; i < BL; i++) pend.push_back(int'(p_addr) + i);
                  rcmd++;
               end
            end else if (p_req) begin
               chk("stall_ctrl", {wr, rd, size}, {p_wr, p_rd, p_size});
               chk("stall_addr", addr, p_addr);
               chk("stall_data", wdata, p_data);
            end
            if (bb) begin
               bb_cnt++;
               chk("bb_first_beat", (wr && wcnt % BL == 0) || rd, 1);
            end
         end else begin
            p_req = 1'b0;
         end
         if (pend.size() > 0 && (!stall_en || $urandom_range(1, 0) == 1)) begin
            a = pend.pop_front();
            rvalid = 1'b1;
            rdata = mem[a] ^ corrupt[a];
         end else begin
            rvalid = junk_en;
            rdata = {$urandom, $urandom, $urandom, $urandom};
         end
         wrn = stall_en ? ($urandom_range(1, 0) == 1) : 1'b1;
         if (!rst && !model_reset) p_req = wr || rd;
         p_wrn = wrn;
         p_wr = wr;
         p_rd = rd;
         p_addr = addr;
         p_data = wdata;
         p_size = size;
      end
   end

   typedef struct {
      logic [1:0] mode;
      bit stall;
      int kind;
      int delay;
      bit glitch;
      bit poke;
      int exp_err;
      int exp_first;
   } vec_t;
   vec_t vecs [8];

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run(input vec_t v);
      int e, f, t;
      bit saw_wr, poked;
      model_reset = 1'b1;
      tb_mode = v.mode;
      stall_en = v.stall;
      for (int w = 0; w < NW; w++) begin
         corrupt[w] = '0;
         if (v.kind == 1 && w == 9) corrupt[w] = DATA_W'(1);
         if (v.kind == 2) corrupt[w] = {DATA_W{1'b1}};
         if (v.kind == 3 && $urandom_range(3, 0) == 0) corrupt[w] = DATA_W'(1) << $urandom_range(DATA_W - 1, 0);
      end
      e = v.exp_err;
      f = v.exp_first;
      if (v.kind == 3) begin
         e = 0;
         f = 0;
         for (int w = NW - 1; w >= 0; w--) if (corrupt[w] != '0) begin
            e++;
            f = w;
         end
      end
      init_done = (v.delay == 0);
      mode_in = v.mode;
      start = 1'b1;
      @(negedge clk);
      model_reset = 1'b0;
      start = 1'b0;
      mode_in = ~v.mode;
      saw_wr = 1'b0;
      repeat (v.delay) begin
         @(negedge clk);
         saw_wr |= wr;
      end
      if (v.delay > 0) begin
         chk("no_write_before_init", saw_wr, 0);
         init_done = 1'b1;
      end
      t = 0;
      poked = 1'b0;
      while (!complete && t < 3000) begin
         @(negedge clk);
         t++;
         start = 1'b0;
         if (v.glitch && wr) init_done = 1'b0;
         if (v.poke && !poked && wcnt >= 5) begin
            start = 1'b1;
            poked = 1'b1;
         end
      end
      start = 1'b0;
      chk("complete_in_time", complete, 1);
      chk("pass", pass, e == 0);
      chk("fail", fail, e != 0);
      chk("err_count", err_cnt, e);
      chk("first_err_addr", first_err, f);
      chk("write_beats", wcnt, NW);
      chk("read_cmds", rcmd, NW / BL);
      chk("burstbegins", bb_cnt, 2 * NW / BL);
      init_done = 1'b1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_write"}, wr, 0);
      chk({tag, "_read"}, rd, 0);
      chk({tag, "_burstbegin"}, bb, 0);
      chk({tag, "_address"}, addr, 0);
      chk({tag, "_writedata"}, wdata, 0);
      chk({tag, "_size"}, size, BL);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_complete"}, complete, 0);
      chk({tag, "_err_count"}, err_cnt, 0);
      chk({tag, "_first_err"}, first_err, 0);
   endtask

   initial begin
      int t;
      vecs[0] = '{2'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0};
      vecs[1] = '{2'd0, 1'b1, 0, 0, 1'b0, 1'b1, 0, 0};
      vecs[2] = '{2'd1, 1'b0, 1, 0, 1'b0, 1'b0, 1, 9};
      vecs[3] = '{2'd2, 1'b0, 2, 0, 1'b0, 1'b0, 16, 0};
      vecs[4] = '{2'd3, 1'b0, 0, 100, 1'b1, 1'b0, 0, 0};
      vecs[5] = '{2'd1, 1'b1, 3, 0, 1'b0, 1'b0, 0, 0};
      vecs[6] = '{2'd2, 1'b1, 0, 0, 1'b0, 1'b0, 0, 0};
      vecs[7] = '{2'd3, 1'b1, 3, 0, 1'b0, 1'b0, 0, 0};
      rst = 1'b1;
      cycles(3);
      chk_reset_values("reset");
      rst = 1'b0;
      junk_en = 1'b1;
      cycles(5);
      junk_en = 1'b0;
      chk("idle_junk_err", err_cnt, 0);
      chk("idle_junk_complete", complete, 0);
      run(vecs[0]);
      junk_en = 1'b1;
      cycles(8);
      junk_en = 1'b0;
      chk("done_hold_complete", complete, 1);
      chk("done_hold_pass", pass, 1);
      chk("done_hold_err", err_cnt, 0);
      for (int i = 1; i < 8; i++) run(vecs[i]);

      // reset in the third write burst, then a clean checkerboard rerun
      model_reset = 1'b1;
      tb_mode = 2'd3;
      stall_en = 1'b1;
      for (int w = 0; w < NW; w++) corrupt[w] = '0;
      mode_in = 2'd3;
      init_done = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_reset = 1'b0;
      t = 0;
      while (wcnt < 9 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("reach_third_burst", wcnt >= 9 && wcnt < 12, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_values("midburst_rst");
      rst = 1'b0;
      run('{2'd3, 1'b1, 0, 0, 1'b0, 1'b0, 0, 0});

      // reset while reads are outstanding; late data must not be counted
      model_reset = 1'b1;
      tb_mode = 2'd0;
      stall_en = 1'b1;
      for (int w = 0; w < NW; w++) corrupt[w] = {DATA_W{1'b1}};
      mode_in = 2'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_reset = 1'b0;
      t = 0;
      while (!(rcmd >= 2 && pend.size() > 2) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("reach_inflight_reads", rcmd >= 2 && pend.size() > 2, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      while (pend.size() > 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      cycles(3);
      chk("inflight_drained", pend.size(), 0);
      chk("inflight_err_count", err_cnt, 0);
      chk("inflight_first_err", first_err, 0);
      chk("inflight_complete", complete, 0);
      chk("inflight_read", rd, 0);
      run(vecs[6]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/avalon_burst_mem_tester.md
AVALON_BURST_MEM_TESTER -- requirements
Module: avalon_burst_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, default 512, data width; multiple of 32.
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per burst, 1..(2**SIZE_W)-1.
REQ-004 SHALL have parameter SIZE_W, default 3, avl_size width.
REQ-005 SHALL have parameter NUM_WORDS, default 1024, words tested from address 0; multiple of BURST_LEN.
REQ-006 SHALL have parameter SEED, default 32'hACE1_2345, LFSR seed, nonzero.
REQ-007 SHALL have ports iCLK in 1, single clock; iRST in 1, synchronous active-high reset.
REQ-008 SHALL have ports iSTART in 1, start pulse; iMODE in 2, pattern select (0 address, 1 LFSR32, 2 walking-one, 3 checkerboard 5555/AAAA by word parity); local_init_done in 1, controller calibrated.
REQ-009 SHALL have Avalon master ports avl_waitrequest_n in 1; avl_address out ADDR_W; avl_burstbegin out 1; avl_size out SIZE_W; avl_write out 1; avl_writedata out DATA_W; avl_read out 1; avl_readdatavalid in 1; avl_readdata in DATA_W.
REQ-010 SHALL have status ports drv_status_pass out 1; drv_status_fail out 1; drv_status_test_complete out 1; err_count out 16, saturating mismatch count; first_err_addr out ADDR_W, word address of first mismatch.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE.
REQ-012 IDLE SHALL go to WAIT_INIT on iSTART=1, latching iMODE and clearing status, counters, err_count, first_err_addr.
REQ-013 WAIT_INIT SHALL hold until local_init_done=1, then enter WRITE.
REQ-014 WRITE SHALL issue NUM_WORDS/BURST_LEN bursts of BURST_LEN beats at addresses 0, BURST_LEN, 2*BURST_LEN, ...
REQ-015 In WRITE, avl_address and avl_size (=BURST_LEN) SHALL be held for the whole burst; avl_burstbegin SHALL be 1 only on the first beat's first presented cycle.
REQ-016 Every request (write beat or read command) SHALL hold address, data and control stable while avl_waitrequest_n=0; a beat or command SHALL advance only on a cycle with avl_waitrequest_n=1.
REQ-017 Word w SHALL carry a 32-bit pattern P(w) replicated DATA_W/32 times: address mode w; LFSR mode the x^32+x^22+x^2+x+1 Galois LFSR stepped once per word from SEED; walking-one 1<<(w mod 32); checkerboard per REQ-008.
REQ-018 After the last write beat is accepted, the FSM SHALL enter READ, restart pattern generation at w=0, and issue one read command per burst (avl_read=1, avl_burstbegin=1, avl_size=BURST_LEN) at the same addresses.
REQ-019 Readdatavalid beats SHALL be compared in order against a separate expected-pattern generator; compare result registered one cycle after the beat.
REQ-020 On mismatch, err_count SHALL increment, saturating at 16'hFFFF; first_err_addr SHALL capture the beat's word address only on the first mismatch.
REQ-021 READ SHALL enter DRAIN after the last read command is accepted; DRAIN SHALL enter DONE once NUM_WORDS beats are received and the last compare has retired.
REQ-022 In DONE: drv_status_test_complete=1; drv_status_pass=1 iff err_count=0; drv_status_fail=~pass; outputs held until iRST or a new iSTART.
REQ-023 iSTART SHALL be ignored in WAIT_INIT, WRITE, READ and DRAIN; in DONE it SHALL restart per REQ-012.
REQ-024 avl_readdatavalid while not in READ or DRAIN SHALL be ignored.
REQ-025 local_init_done falling mid-test SHALL NOT abort; the FSM SHALL continue per handshake.

Reset
REQ-026 On iCLK edge with iRST=1: FSM to IDLE; avl_write, avl_read, avl_burstbegin, avl_address, avl_writedata, all drv_status_*, err_count and first_err_addr SHALL be 0; avl_size SHALL be BURST_LEN.
REQ-027 iRST mid-burst SHALL drop requests in the same cycle; in-flight read data arriving afterward SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold state encodings, iMODE constants and the LFSR polynomial constant.
REQ-029 Pattern generation SHALL be one sub-module, mem_test_pattern_gen (inputs mode, restart, advance; output DATA_W word), instantiated twice: write/read-issue and expected-check.

Verification
REQ-030 Zero-wait memory model, NUM_WORDS=16, BURST_LEN=4, mode 0, iSTART pulse -> 4 write bursts at 0,4,8,12; 4 read commands; DONE with pass=1, err_count=0.
REQ-031 Random avl_waitrequest_n (50%) -> address/data/control stable while stalled; burstbegin once per burst; pass=1.
REQ-032 Model corrupts bit 0 of word 9, mode 1 -> fail=1, err_count=1, first_err_addr=9.
REQ-033 Model returns wrong data for every word, NUM_WORDS=16, mode 2 -> err_count=16, first_err_addr=0, fail=1.
REQ-034 local_init_done=0 for 100 cycles after iSTART -> no avl_write until it rises; then completes with pass=1.
REQ-035 iRST asserted during third write burst, then iSTART, mode 3 -> outputs at REQ-026 values next cycle; rerun completes with pass=1.
